// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU sharing arbiter: FSM state encoding,
// ALU select field positions and a select-packing helper.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Bit positions of the ALU select lines inside the packed {s4..s0} bus
  localparam int S0 = 0;
  localparam int S1 = 1;
  localparam int S2 = 2;
  localparam int S3 = 3;
  localparam int S4 = 4;

  // Builds the packed select word from individual ALU select lines
  function automatic logic [4:0] pack_sel(input logic s4, input logic s3,
                                          input logic s2, input logic s1,
                                          input logic s0);
    logic [4:0] r;
    r     = 5'b00000;
    r[S4] = s4;
    r[S3] = s3;
    r[S2] = s2;
    r[S1] = s1;
    r[S0] = s0;
    return r;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two clients and the arbiter.
// Requester i owns slice [i*DW +: DW] of req_a/req_b and [i*SELW +: SELW]
// of req_sel; rsp_data/rsp_cout are a shared bus qualified by rsp_valid.
interface alu_share_arbiter_if #(
  parameter int DW   = 4,
  parameter int SELW = 5
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*DW-1:0]   req_a;
  logic [2*DW-1:0]   req_b;
  logic [2*SELW-1:0] req_sel;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic              rsp_cout;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_cout
  );

  // Client side
  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_cout
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Grant is one-hot and combinational from the
// valid bits and the pointer; the pointer moves to the loser of each accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  logic ptr_r;

  // Single requester wins outright; on contention the pointer decides
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_r ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer points at the requester that did not win the last accept
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (advance) begin
      ptr_r <= ~grant[1];
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational 4-bit ALU between two requesters. One operation
// is in flight at a time: IDLE accepts a request, EXEC drives the ALU from
// the operand registers and samples its result, RESP holds the result for
// the owner until it is accepted.
// Build option: define ALU_ARB_GRANT_CNT_EN to enable per-requester accept
// counters on grant_cnt; otherwise grant_cnt is constant zero.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DW   = 4,
  parameter int SELW = 5,
  parameter int CNTW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_share_arbiter_if.slave   bus,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  output logic [SELW-1:0]      alu_sel,
  input  logic [DW-1:0]        alu_o,
  input  logic                 alu_cout,
  output logic [2*CNTW-1:0]    grant_cnt
);

  state_t            state_r;
  state_t            state_nxt_s;
  logic              owner_r;
  logic [DW-1:0]     a_r;
  logic [DW-1:0]     b_r;
  logic [SELW-1:0]   sel_r;
  logic [DW-1:0]     res_r;
  logic              cout_r;

  logic [1:0]        grant_s;
  logic              ptr_s;
  logic              win_s;
  logic              accept_s;
  logic [1:0]        ready_s;
  logic [1:0]        rsp_valid_s;
  logic [DW-1:0]     a_in_s;
  logic [DW-1:0]     b_in_s;
  logic [SELW-1:0]   sel_in_s;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (bus.req_valid),
    .advance (accept_s),
    .grant   (grant_s),
    .ptr     (ptr_s)
  );

  // Index of the requester that would be accepted this cycle
  always_comb begin
    win_s = 1'b0;
    if (bus.req_valid == 2'b11) begin
      win_s = ptr_s;
    end else begin
      win_s = bus.req_valid[1];
    end
  end

  assign a_in_s   = win_s ? bus.req_a[DW +: DW]       : bus.req_a[0 +: DW];
  assign b_in_s   = win_s ? bus.req_b[DW +: DW]       : bus.req_b[0 +: DW];
  assign sel_in_s = win_s ? bus.req_sel[SELW +: SELW] : bus.req_sel[0 +: SELW];

  // Next-state, request handshake and response-valid decode
  always_comb begin
    state_nxt_s = state_r;
    ready_s     = 2'b00;
    accept_s    = 1'b0;
    rsp_valid_s = 2'b00;
    case (state_r)
      ST_IDLE: begin
        ready_s = grant_s & bus.req_valid;
        if (ready_s != 2'b00) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_nxt_s = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_s[owner_r] = 1'b1;
        if (bus.rsp_ready[owner_r]) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, latched operands and captured ALU result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      owner_r <= 1'b0;
      a_r     <= {DW{1'b0}};
      b_r     <= {DW{1'b0}};
      sel_r   <= {SELW{1'b0}};
      res_r   <= {DW{1'b0}};
      cout_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        owner_r <= win_s;
        a_r     <= a_in_s;
        b_r     <= b_in_s;
        sel_r   <= sel_in_s;
      end
      if (state_r == ST_EXEC) begin
        res_r  <= alu_o;
        cout_r <= alu_cout;
      end
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_data  = res_r;
  assign bus.rsp_cout  = cout_r;

  assign alu_a   = a_r;
  assign alu_b   = b_r;
  assign alu_sel = sel_r;

`ifdef ALU_ARB_GRANT_CNT_EN
  logic [CNTW-1:0] cnt0_r;
  logic [CNTW-1:0] cnt1_r;

  // Accept counters per requester; wrap from all-ones back to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_r <= {CNTW{1'b0}};
      cnt1_r <= {CNTW{1'b0}};
    end else if (accept_s) begin
      if (win_s) begin
        cnt1_r <= cnt1_r + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
        cnt0_r <= cnt0_r + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign grant_cnt = {cnt1_r, cnt0_r};
`else
  assign grant_cnt = {(2*CNTW){1'b0}};
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized, scoreboard-checked bench for alu_share_arbiter with a
// behavioural ALU attached to the alu_* ports.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int DW   = 4;
  localparam int SELW = 5;
  localparam int CNTW = 8;

  typedef struct {
    bit         owner;
    logic [3:0] d;
    logic       c;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   alu_a, alu_b, alu_o;
  logic [SELW-1:0] alu_sel;
  logic            alu_cout;
  logic [2*CNTW-1:0] grant_cnt;

  int cyc   = 0;
  int n_chk = 0;
  int n_bad = 0;

  exp_t exp_q[$];
  int   gq[$];

  logic [4:0] sel_add;
  logic [4:0] sel_sub;

  alu_share_arbiter_if #(.DW(DW), .SELW(SELW)) ifc ();

  alu_share_arbiter #(.DW(DW), .SELW(SELW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_o     (alu_o),
    .alu_cout  (alu_cout),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural ALU: op in s2..s0, s3 = carry-in for add, s4 inverts result
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [4:0] s);
    logic [4:0] r;
    case (s[2:0])
      3'd0:    r = {1'b0, a} + {1'b0, b} + {4'b0000, s[S3]};
      3'd1:    r = {1'b0, a} + {1'b0, ~b} + 5'd1;
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a ^ b};
      3'd5:    r = {1'b0, a} + 5'd1;
      3'd6:    r = {1'b0, ~a};
      default: r = {1'b0, b};
    endcase
    if (s[S4]) r[3:0] = ~r[3:0];
    return r;
  endfunction

  always_comb {alu_cout, alu_o} = alu_f(alu_a, alu_b, alu_sel);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit i, input logic [3:0] a, input logic [3:0] b,
                         input logic [4:0] s);
    if (i) begin
      ifc.req_a[7:4] = a;  ifc.req_b[7:4] = b;  ifc.req_sel[9:5] = s;
    end else begin
      ifc.req_a[3:0] = a;  ifc.req_b[3:0] = b;  ifc.req_sel[4:0] = s;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model: handshake, latency, counters -------
  bit         m_busy, m_ptr, m_owner, m_w;
  int         m_acc, m_cnt0, m_cnt1;
  logic [1:0] m_v, m_rdy, m_rv;
  logic [15:0] m_cnt_exp;
  exp_t       m_e;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_owner = 0; m_cnt0 = 0; m_cnt1 = 0;
      exp_q.delete();
    end else begin
      m_v   = ifc.req_valid;
      m_rdy = 2'b00;
      m_w   = 1'b0;
      if (!m_busy && m_v != 2'b00) begin
        m_w   = (m_v == 2'b11) ? m_ptr : m_v[1];
        m_rdy = m_w ? 2'b10 : 2'b01;
      end
      chk("req_ready", {30'd0, ifc.req_ready}, {30'd0, m_rdy});
      m_rv = (m_busy && cyc >= m_acc + 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("rsp_valid", {30'd0, ifc.rsp_valid}, {30'd0, m_rv});
`ifdef ALU_ARB_GRANT_CNT_EN
      m_cnt_exp = {m_cnt1[7:0], m_cnt0[7:0]};
`else
      m_cnt_exp = 16'h0000;
`endif
      chk("grant_cnt", {16'd0, grant_cnt}, {16'd0, m_cnt_exp});
      if (m_rv != 2'b00) begin
        if (ifc.rsp_ready[m_owner]) m_busy = 0;
      end else if (m_rdy != 2'b00) begin
        m_e.owner = m_w;
        {m_e.c, m_e.d} = m_w ? alu_f(ifc.req_a[7:4], ifc.req_b[7:4], ifc.req_sel[9:5])
                             : alu_f(ifc.req_a[3:0], ifc.req_b[3:0], ifc.req_sel[4:0]);
        exp_q.push_back(m_e);
        m_busy = 1; m_owner = m_w; m_acc = cyc; m_ptr = ~m_w;
        if (m_w) m_cnt1++; else m_cnt0++;
      end
    end
  end

  // ---------------- response monitor / scoreboard -----------------------
  logic [1:0] mon_pv;
  logic [3:0] mon_pd;
  logic       mon_pc;
  exp_t       mon_e;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      mon_pv = 2'b00;
    end else if (ifc.rsp_valid != 2'b00) begin
      if (mon_pv == ifc.rsp_valid) begin
        chk("rsp_hold_data", {28'd0, ifc.rsp_data}, {28'd0, mon_pd});
        chk("rsp_hold_cout", {31'd0, ifc.rsp_cout}, {31'd0, mon_pc});
      end
      if ((ifc.rsp_valid & ifc.rsp_ready) != 2'b00) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_bad++;
          $display("FAIL sb_empty: got response data %0h with no expected entry", ifc.rsp_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_owner", {30'd0, ifc.rsp_valid}, {30'd0, (mon_e.owner ? 2'b10 : 2'b01)});
          chk("sb_data", {28'd0, ifc.rsp_data}, {28'd0, mon_e.d});
          chk("sb_cout", {31'd0, ifc.rsp_cout}, {31'd0, mon_e.c});
        end
        mon_pv = 2'b00;
      end else begin
        mon_pv = ifc.rsp_valid; mon_pd = ifc.rsp_data; mon_pc = ifc.rsp_cout;
      end
    end else begin
      mon_pv = 2'b00;
    end
  end

  // ---------------- directed helpers ------------------------------------
  task automatic single(input bit i, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] s, input logic [3:0] ed, input logic ec,
                        input string nm);
    int c0;
    bit seen;
    logic [1:0] one;
    one = i ? 2'b10 : 2'b01;
    set_req(i, a, b, s);
    ifc.req_valid = one;
    @(negedge clk);
    chk({nm, "_ready"}, {30'd0, ifc.req_ready}, {30'd0, one});
    c0 = cyc;
    tick();
    ifc.req_valid = 2'b00;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (ifc.rsp_valid != 2'b00) seen = 1;
    end
    chk({nm, "_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      chk({nm, "_lat"},   cyc - c0, 32'd2);
      chk({nm, "_owner"}, {30'd0, ifc.rsp_valid}, {30'd0, one});
      chk({nm, "_data"},  {28'd0, ifc.rsp_data}, {28'd0, ed});
      chk({nm, "_cout"},  {31'd0, ifc.rsp_cout}, {31'd0, ec});
    end
    tick();
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_alu_a"},   {28'd0, alu_a}, 32'd0);
    chk({nm, "_alu_b"},   {28'd0, alu_b}, 32'd0);
    chk({nm, "_alu_sel"}, {27'd0, alu_sel}, 32'd0);
    chk({nm, "_rdata"},   {28'd0, ifc.rsp_data}, 32'd0);
    chk({nm, "_rcout"},   {31'd0, ifc.rsp_cout}, 32'd0);
    chk({nm, "_gcnt"},    {16'd0, grant_cnt}, 32'd0);
  endtask

  task automatic rst_mid(input bit in_resp, input string nm);
    ifc.rsp_ready = in_resp ? 2'b00 : 2'b11;
    set_req(1'b0, 4'h9, 4'h4, sel_add);
    ifc.req_valid = 2'b01;
    tick();
    ifc.req_valid = 2'b00;
    if (in_resp) begin
      tick();
      @(negedge clk);
      chk({nm, "_pre"}, {30'd0, ifc.rsp_valid}, 32'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.rsp_ready = 2'b11;
    @(negedge clk);
    check_reset_vals(nm);
    for (int k = 0; k < 4; k++) begin
      chk({nm, "_norsp"}, {30'd0, ifc.rsp_valid}, 32'd0);
      tick();
      @(negedge clk);
    end
    tick();
    set_req(1'b0, 4'h3, 4'h5, sel_add);
    set_req(1'b1, 4'h1, 4'h1, sel_add);
    ifc.req_valid = 2'b11;
    @(negedge clk);
    chk({nm, "_first"}, {30'd0, ifc.req_ready}, 32'd1);
    tick();
    ifc.req_valid = 2'b00;
    repeat (4) tick();
  endtask

  // ---------------- main sequence ---------------------------------------
  initial begin
    sel_add = pack_sel(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sel_sub = pack_sel(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    ifc.req_valid = 2'b00; ifc.rsp_ready = 2'b11;
    ifc.req_a = 8'h00; ifc.req_b = 8'h00; ifc.req_sel = 10'h000;
    do_reset(3);

    @(negedge clk);
    check_reset_vals("reset");
    chk("reset_rsp_valid", {30'd0, ifc.rsp_valid}, 32'd0);
    chk("reset_req_ready", {30'd0, ifc.req_ready}, 32'd0);
    tick();

    single(1'b0, 4'h3, 4'h5, sel_add, 4'h8, 1'b0, "add0");
    single(1'b0, 4'hF, 4'h1, sel_add, 4'h0, 1'b1, "ovf");
    single(1'b1, 4'h3, 4'h5, sel_sub, 4'hE, 1'b0, "sub1");

    // contention right after reset: alternation starting with requester 0
    do_reset(2);
    ifc.req_valid = 2'b11;
    gq.delete();
    for (int k = 0; k < 40 && gq.size() < 4; k++) begin
      set_req(1'b0, 4'($urandom), 4'($urandom), 5'($urandom));
      set_req(1'b1, 4'($urandom), 4'($urandom), 5'($urandom));
      @(negedge clk);
      if (ifc.req_ready != 2'b00) gq.push_back(int'(ifc.req_ready[1]));
      tick();
    end
    ifc.req_valid = 2'b00;
    chk("rr_count", gq.size(), 32'd4);
    for (int k = 0; k < gq.size(); k++) chk("rr_order", gq[k], k % 2);
    repeat (4) tick();

    // response backpressure; non-owner rsp_ready must be ignored
    ifc.rsp_ready = 2'b10;
    set_req(1'b0, 4'h7, 4'h6, sel_add);
    ifc.req_valid = 2'b01;
    tick();
    ifc.req_valid = 2'b00;
    tick();
    @(negedge clk);
    chk("bp_valid0", {30'd0, ifc.rsp_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      ifc.req_valid = 2'b11;
      @(negedge clk);
      chk("bp_ready", {30'd0, ifc.req_ready}, 32'd0);
      chk("bp_valid", {30'd0, ifc.rsp_valid}, 32'd1);
      chk("bp_data",  {28'd0, ifc.rsp_data}, 32'hD);
    end
    tick();
    ifc.req_valid = 2'b00;
    ifc.rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_last", {30'd0, ifc.rsp_valid}, 32'd1);
    tick();
    @(negedge clk);
    chk("bp_done", {30'd0, ifc.rsp_valid}, 32'd0);
    tick();

    rst_mid(1'b0, "rst_exec");
    rst_mid(1'b1, "rst_resp");

    // randomized traffic with random payload churn and response stalls
    for (int k = 0; k < 400; k++) begin
      tick();
      ifc.req_valid = 2'($urandom_range(0, 3));
      ifc.req_a     = 8'($urandom);
      ifc.req_b     = 8'($urandom);
      ifc.req_sel   = 10'($urandom);
      ifc.rsp_ready = 2'($urandom_range(0, 3));
    end
    tick();
    ifc.req_valid = 2'b00;
    ifc.rsp_ready = 2'b11;
    repeat (5) tick();

    // 257 accepts by requester 1 from reset
    do_reset(2);
    ifc.req_valid = 2'b10;
    for (int k = 0; k < 3000 && m_cnt1 < 257; k++) begin
      set_req(1'b1, 4'($urandom), 4'($urandom), 5'($urandom));
      tick();
    end
    ifc.req_valid = 2'b00;
    repeat (4) tick();
    @(negedge clk);
`ifdef ALU_ARB_GRANT_CNT_EN
    chk("cnt_wrap_hi", {24'd0, grant_cnt[15:8]}, 32'd1);
`else
    chk("cnt_wrap_hi", {24'd0, grant_cnt[15:8]}, 32'd0);
`endif
    chk("cnt_wrap_lo", {24'd0, grant_cnt[7:0]}, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

endmodule
